vga_timing_gen: RTL and testbench

- Source end of the pixel-scan interface consumed by the sprite renderers (the ROM/palette pixel blocks), e.g. the promotion-menu sprite.
- Generates 640x480@60 Hz raster timing from the 25 MHz pixel clock: DrawX/DrawY scan position, active-video `blank`, active-low hs/vs.
- Provides frame-level strobes so game logic (board/promotion FSMs) can update state during vertical blanking.

---
 rtl/vga_timing_gen.sv | 119 +++++++++++
 tb/tb_vga_timing_gen.sv | 124 ++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing: registered scan position, syncs, blank and frame strobes.
// Define VGA_SYNC_DELAY_EN to delay hs/vs/blank by one clock behind DrawX/DrawY.
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33
) (
    input  logic       vga_clk,
    input  logic       reset,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       frame_start,
    output logic       vblank_start,
    output logic [7:0] frame_count
);

    localparam int unsigned H_TOTAL    = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL    = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_SYNC_BEG = H_VISIBLE + H_FP;
    localparam int unsigned H_SYNC_END = H_VISIBLE + H_FP + H_SYNC;
    localparam int unsigned V_SYNC_BEG = V_VISIBLE + V_FP;
    localparam int unsigned V_SYNC_END = V_VISIBLE + V_FP + V_SYNC;
    localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_timing
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must each be <= 1024");
    end

    logic [9:0] hc_q, hc_d;
    logic [9:0] vc_q, vc_d;
    logic       h_wrap, v_wrap;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       blank_q, blank_d;
    logic       frame_start_q, frame_start_d;
    logic       vblank_start_q, vblank_start_d;
    logic [7:0] frame_count_q, frame_count_d;

    // Decode is done on the next counter values so the registered strobes line up
    // with the registered position presented in the same cycle.
    always_comb begin
        h_wrap = (hc_q == H_LAST);
        v_wrap = (vc_q == V_LAST);
        hc_d   = h_wrap ? 10'd0 : hc_q + 10'd1;
        vc_d   = vc_q;
        if (h_wrap) begin
            vc_d = v_wrap ? 10'd0 : vc_q + 10'd1;
        end
        hs_d           = !((32'(hc_d) >= H_SYNC_BEG) && (32'(hc_d) < H_SYNC_END));
        vs_d           = !((32'(vc_d) >= V_SYNC_BEG) && (32'(vc_d) < V_SYNC_END));
        blank_d        = (32'(hc_d) < H_VISIBLE) && (32'(vc_d) < V_VISIBLE);
        frame_start_d  = h_wrap && v_wrap;
        vblank_start_d = (hc_d == 10'd0) && (32'(vc_d) == V_VISIBLE);
        frame_count_d  = frame_count_q + {7'd0, frame_start_d};
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            hc_q           <= 10'd0;
            vc_q           <= 10'd0;
            hs_q           <= 1'b1;
            vs_q           <= 1'b1;
            blank_q        <= 1'b1;
            frame_start_q  <= 1'b0;
            vblank_start_q <= 1'b0;
            frame_count_q  <= 8'd0;
        end else begin
            hc_q           <= hc_d;
            vc_q           <= vc_d;
            hs_q           <= hs_d;
            vs_q           <= vs_d;
            blank_q        <= blank_d;
            frame_start_q  <= frame_start_d;
            vblank_start_q <= vblank_start_d;
            frame_count_q  <= frame_count_d;
        end
    end

`ifdef VGA_SYNC_DELAY_EN
    logic hs_dly_q, vs_dly_q, blank_dly_q;

    // Extra stage matches renderers that register RGB one clock after sampling DrawX/DrawY.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            hs_dly_q    <= 1'b1;
            vs_dly_q    <= 1'b1;
            blank_dly_q <= 1'b0;
        end else begin
            hs_dly_q    <= hs_q;
            vs_dly_q    <= vs_q;
            blank_dly_q <= blank_q;
        end
    end

    assign hs    = hs_dly_q;
    assign vs    = vs_dly_q;
    assign blank = blank_dly_q;
`else
    assign hs    = hs_q;
    assign vs    = vs_q;
    assign blank = blank_q;
`endif

    assign DrawX        = hc_q;
    assign DrawY        = vc_q;
    assign frame_start  = frame_start_q;
    assign vblank_start = vblank_start_q;
    assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken raster: the reference model derives every output
// from the number of pixel clocks elapsed since the last reset.
module tb_vga_timing_gen;

    localparam int HV  = 8;
    localparam int HFP = 2;
    localparam int HS  = 3;
    localparam int HBP = 2;
    localparam int VV  = 6;
    localparam int VFP = 1;
    localparam int VS  = 2;
    localparam int VBP = 2;
    localparam int HT  = HV + HFP + HS + HBP;
    localparam int VT  = VV + VFP + VS + VBP;
    localparam int FT  = HT * VT;

    logic       vga_clk = 1'b0;
    logic       reset = 1'b1;
    logic       hs, vs, blank, frame_start, vblank_start;
    logic [9:0] DrawX, DrawY;
    logic [7:0] frame_count;

    int checks = 0;
    int errors = 0;

    // Model state: clocks since reset, plus the previous cycle's sync/blank for the delay option.
    int n = 0;
    logic d_hs = 1'b1, d_vs = 1'b1, d_blank = 1'b0;

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
    ) dut (
        .vga_clk     (vga_clk),
        .reset       (reset),
        .hs          (hs),
        .vs          (vs),
        .blank       (blank),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .frame_start (frame_start),
        .vblank_start(vblank_start),
        .frame_count (frame_count)
    );

    always #20 vga_clk = ~vga_clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (clock %0d since reset, t=%0t)",
                     tag, obs, exp, n, $time);
        end
    endtask

    function automatic logic m_hs(input int k);
        int x = k % HT;
        return !(x >= HV + HFP && x < HV + HFP + HS);
    endfunction

    function automatic logic m_vs(input int k);
        int y = (k / HT) % VT;
        return !(y >= VV + VFP && y < VV + VFP + VS);
    endfunction

    function automatic logic m_blank(input int k);
        return ((k % HT) < HV) && (((k / HT) % VT) < VV);
    endfunction

    task automatic check_all();
        logic e_hs, e_vs, e_blank;
`ifdef VGA_SYNC_DELAY_EN
        e_hs = d_hs; e_vs = d_vs; e_blank = d_blank;
`else
        e_hs = m_hs(n); e_vs = m_vs(n); e_blank = m_blank(n);
`endif
        check_eq("DrawX", 32'(DrawX), 32'(n % HT));
        check_eq("DrawY", 32'(DrawY), 32'((n / HT) % VT));
        check_eq("hs", 32'(hs), 32'(e_hs));
        check_eq("vs", 32'(vs), 32'(e_vs));
        check_eq("blank", 32'(blank), 32'(e_blank));
        check_eq("frame_start", 32'(frame_start), 32'(n > 0 && n % FT == 0));
        check_eq("vblank_start", 32'(vblank_start),
                 32'((n % HT) == 0 && ((n / HT) % VT) == VV));
        check_eq("frame_count", 32'(frame_count), 32'((n / FT) % 256));
    endtask

    // One clock with the given reset level, then advance the model and compare.
    task automatic step(input logic r);
        reset = r;
        @(posedge vga_clk);
        #1;
        if (r) begin
            n = 0;
            d_hs = 1'b1; d_vs = 1'b1; d_blank = 1'b0;
        end else begin
            d_hs = m_hs(n); d_vs = m_vs(n); d_blank = m_blank(n);
            n++;
        end
        check_all();
    endtask

    initial begin
        repeat (3) step(1'b1);
        // Long unbroken run: covers many frames and the frame_count 255 -> 0 wrap.
        for (int i = 0; i < 257 * FT + 40; i++) step(1'b0);
        check_eq("frame_count_wrapped", 32'(frame_count), 32'(1));

        // Directed single-cycle reset in the middle of a frame.
        while (!((n % HT) == 5 && ((n / HT) % VT) == 3)) step(1'b0);
        step(1'b1);
        check_eq("midframe_reset_x", 32'(DrawX), 32'(0));
        for (int i = 0; i < FT + 10; i++) step(1'b0);

        // Random short resets sprinkled through a few frames.
        for (int i = 0; i < 3000; i++) step($urandom_range(0, 79) == 0);
        for (int i = 0; i < 2 * FT; i++) step(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
